// File: rtl/mul_share_arb.sv
// Arbiter sharing one external 16x16 (mod 2^16) multiplier core among NREQ requesters.
// Define MUL_SHARE_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy,
  output logic [15:0]        mul_i1,
  output logic [15:0]        mul_i2,
  input  logic [15:0]        mul_o
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [3:0] LAST = 4'(LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic [15:0]     mul_i1_q, mul_i1_d;
  logic [15:0]     mul_i2_q, mul_i2_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [15:0]     a_arr [NREQ];
  logic [15:0]     b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[16*g +: 16];
    assign b_arr[g] = req_b[16*g +: 16];
  end

`ifdef MUL_SHARE_FIXED_PRIO_EN
  // Descending scan: the last hit, i.e. the lowest valid index, wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[ID_W'(i)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Descending offset scan from rr_ptr: the smallest offset that is valid wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr_q) + i) % NREQ);
      if (req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && grant_vld) begin
      rr_ptr_d = ID_W'((int'(grant_id) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // rst_n gates the grant so no requester sees ready while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // NOTE: every _d is first defaulted to its _q so no path through the case leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    mul_i1_d    = mul_i1_q;
    mul_i2_d    = mul_i2_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          mul_i1_d = a_arr[grant_id];
          mul_i2_d = b_arr[grant_id];
          id_d     = grant_id;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          rsp_data_d  = mul_o;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      mul_i1_q    <= '0;
      mul_i2_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      mul_i1_q    <= mul_i1_d;
      mul_i2_q    <= mul_i2_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign mul_i1    = mul_i1_q;
  assign mul_i2    = mul_i2_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb (NREQ=4, LAT=2) with a behavioural multiplier core.
// Expected grant order follows MUL_SHARE_FIXED_PRIO_EN when it is defined.
module tb_mul_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] mul_i1;
  logic [15:0] mul_i2;
  logic [15:0] mul_o;

  int n_checks = 0;
  int n_fail   = 0;

  mul_share_arb #(.NREQ(4), .ID_W(2), .LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .mul_i1    (mul_i1),
    .mul_i2    (mul_i2),
    .mul_o     (mul_o)
  );

  assign mul_o = mul_i1 * mul_i2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, "_mul_i1"},    32'(mul_i1),    32'd0);
    check({tag, "_mul_i2"},    32'(mul_i2),    32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // One operation from a lone requester; hold > 0 keeps rsp_ready low with all others pending.
  task automatic run_op(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input int hold);
    int k;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid = 4'(1 << id);
    rsp_ready = 1'b0;
    #1 check("op_req_ready", 32'(req_ready), 32'(1 << id));
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        req_valid = '0;
        check("op_busy_calc", 32'(busy), 32'd1);
        check("op_mul_i1", 32'(mul_i1), 32'(a));
        check("op_mul_i2", 32'(mul_i2), 32'(b));
        check("op_calc_ready", 32'(req_ready), 32'd0);
      end
    end while (!rsp_valid && k < 20);
    check("op_latency", 32'(k), 32'd3);
    check("op_rsp_data", 32'(rsp_data), 32'(exp));
    check("op_rsp_id", 32'(rsp_id), 32'(id));
    if (hold > 0) req_valid = 4'b1111;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'(exp));
      check("bp_rsp_id", 32'(rsp_id), 32'(id));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("op_done_valid", 32'(rsp_valid), 32'd0);
    check("op_done_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
  endtask

  logic [1:0] exp_ids [5];
  int k;

  initial begin
`ifdef MUL_SHARE_FIXED_PRIO_EN
    exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    req_valid = '0;
    rst_n     = 1'b1;

    // Reset during CALC aborts the operation.
    @(negedge clk);
    req_a[15:0] = 16'd5;
    req_b[15:0] = 16'd7;
    req_valid   = 4'b0001;
    #1 check("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_mul_i1", 32'(mul_i1), 32'd5);
    check("abort_mul_i2", 32'(mul_i2), 32'd7);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end

    run_op(2'd2, 16'd300, 16'd200, 16'hEA60, 0);
    run_op(2'd1, 16'hFFFF, 16'hFFFF, 16'h0001, 5);
    run_op(2'd3, 16'h1234, 16'h0010, 16'h2340, 0);

    // All requesters valid with rsp_ready high: grant order and LAT+2 spacing.
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'h0100;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!rsp_valid && k < 20);
      check("rr_spacing", 32'(k), (n == 0) ? 32'd3 : 32'd4);
      check("rr_rsp_id", 32'(rsp_id), 32'(exp_ids[n]));
      check("rr_rsp_data", 32'(rsp_data), 32'((exp_ids[n] + 1) << 8));
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("end_idle", 32'(busy), 32'd0);
    check("end_no_rsp", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Sequencing arbiter that shares one combinational 16x16 quarter-square multiplier (16-bit truncated product) between NREQ requesters. It accepts one operand pair at a time through a valid/ready handshake and drives the operands into the shared core. After a programmable settle time it captures the product and returns it on a single response channel tagged with the requester index. It sits between the datapath clients and the multiplier core, and it is the only block that drives the core inputs.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- ID_W, 2, width of rsp_id; must equal ceil(log2(NREQ)), minimum 1
- LAT, 2, number of cycles the operands are held on the core before the product is captured; legal range 1..15
- clk  in  1  single clock; all state is updated on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  16*NREQ  operand A; requester i uses bits [16i+15:16i]
- req_b  in  16*NREQ  operand B; same packing as req_a
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts the product
- rsp_data  out  16  product, (A*B) mod 2^16
- rsp_id  out  ID_W  index of the requester that owns rsp_data
- busy  out  1  high in every state other than IDLE
- mul_i1  out  16  shared core operand 1 (registered)
- mul_i2  out  16  shared core operand 2 (registered)
- mul_o  in  16  shared core product

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Winner g is selected combinationally from req_valid.
  - req_ready[g]=1, all other bits 0. No requester valid → req_ready=0.
  - A transfer (valid & ready) latches req_a[g]→mul_i1, req_b[g]→mul_i2, g→id register, clears cnt, and moves to CALC.
- CALC:
  - mul_i1 and mul_i2 are held stable; cnt increments each cycle.
  - When cnt==LAT-1: mul_o→rsp_data, id→rsp_id, rsp_valid←1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - rsp_ready=1 → rsp_valid←0 and go to IDLE. Otherwise remain in RESP.
- req_ready is 0 in CALC and RESP. Only one operation is ever in flight.
- Arbitration (default): round-robin.
  - Pointer rr_ptr resets to 0. The search runs from rr_ptr upward, modulo NREQ.
  - After a grant to g: rr_ptr←(g+1) mod NREQ.
- Simultaneous events: every requester valid at once → exactly one grant, per the arbitration rule. A req_valid deassertion while not ready is legal; that request is simply not taken.
- Operands keep their 16-bit width. No sign handling; the product is the core's 16-bit output taken unmodified.

## Timing
- Reset values (asynchronous): state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, mul_i1=0, mul_i2=0, cnt=0, rr_ptr=0, busy=0. req_ready is forced to 0 while rst_n is low.
- Accept in cycle T → CALC occupies T+1..T+LAT → rsp_valid first high at T+LAT+1.
- With rsp_ready held high: the next accept happens no earlier than T+LAT+2, giving a minimum spacing of LAT+2 cycles.
- Reset asserted mid-operation aborts the in-flight operation. No response is produced and the FSM restarts in IDLE.

## Configuration
- MUL_SHARE_FIXED_PRIO_EN:
  - Defined: fixed priority, where the lowest asserted index always wins. rr_ptr is not implemented.
  - Undefined: round-robin as described under Operation.
- All handshake and timing behaviour is identical in both builds.

## Test plan
- Reset mid-CALC: req0 A=5 B=7 accepted, rst_n pulsed low during CALC → no rsp_valid, every output at its reset value, and a new request is then accepted normally.
- Single op, NREQ=4, LAT=2: req2 A=300 B=200 accepted at cycle T → rsp_valid at T+3 with rsp_data=0xEA60 and rsp_id=2.
- Wrap-around: A=0xFFFF B=0xFFFF → rsp_data=0x0001. A=0x1234 B=0x0010 → rsp_data=0x2340.
- Round-robin: all four req_valid held high with rsp_ready=1 → grants in order 0,1,2,3,0. With MUL_SHARE_FIXED_PRIO_EN defined → grants 0,0,0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_data, rsp_id and rsp_valid stay stable, req_ready stays 0, and pending requests wait. Releasing rsp_ready → IDLE on the next cycle.
